gray_to_rgb_stream: RTL

Streaming 8-bit grayscale to 24-bit RGB expander. It performs the inverse-direction conversion for the display path and sits between the gray processing chain and the RGB display or output formatter. It is an elastic 2-stage valid/ready pipeline that carries sof/eol sideband with each pixel. It also checks line length and counts frames.

---
 rtl/vid_pkg.sv | 23 ++
 rtl/gray_colormap.sv | 28 ++
 rtl/gray_to_rgb_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared video types and constants for the gray/RGB display path.
// The heatmap segment constants are used only when GRAY_HEATMAP_EN is defined.
package vid_pkg;

  localparam int GRAY_W = 8;
  localparam int RGB_W  = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Heatmap segments are selected by gray[7:6] and named by their colour ramp
  localparam logic [1:0] SEG_BLUE_CYAN    = 2'd0;
  localparam logic [1:0] SEG_CYAN_GREEN   = 2'd1;
  localparam logic [1:0] SEG_GREEN_YELLOW = 2'd2;
  localparam logic [1:0] SEG_YELLOW_RED   = 2'd3;

  localparam logic [7:0] CH_MAX = 8'hFF;
  localparam logic [7:0] CH_MIN = 8'h00;

endpackage

// File: rtl/gray_colormap.sv
// Combinational gray -> RGB mapping: replication by default, or a 4-segment
// heatmap when GRAY_HEATMAP_EN is defined.
module gray_colormap
  import vid_pkg::*;
(
  input  logic [GRAY_W-1:0] gray_i,
  output rgb_t              rgb_o
);

`ifdef GRAY_HEATMAP_EN
  logic [7:0] ramp;
  assign ramp = {gray_i[5:0], 2'b00};

  always_comb begin
    rgb_o = '{r: CH_MIN, g: CH_MIN, b: CH_MIN};
    unique case (gray_i[7:6])
      SEG_BLUE_CYAN:    rgb_o = '{r: CH_MIN, g: ramp,          b: CH_MAX};
      SEG_CYAN_GREEN:   rgb_o = '{r: CH_MIN, g: CH_MAX,        b: CH_MAX - ramp};
      SEG_GREEN_YELLOW: rgb_o = '{r: ramp,   g: CH_MAX,        b: CH_MIN};
      SEG_YELLOW_RED:   rgb_o = '{r: CH_MAX, g: CH_MAX - ramp, b: CH_MIN};
      default:          rgb_o = '{r: CH_MIN, g: CH_MIN,        b: CH_MIN};
    endcase
  end
`else
  assign rgb_o = '{r: gray_i, g: gray_i, b: gray_i};
`endif

endmodule

// File: rtl/gray_to_rgb_stream.sv
// Elastic two-stage gray -> RGB stream with sof/eol sideband, line-length check
// and frame counter. Mapping style is selected by GRAY_HEATMAP_EN (see gray_colormap).
module gray_to_rgb_stream
  import vid_pkg::*;
#(
  parameter int LINE_W = 640,
  parameter int COL_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [GRAY_W-1:0] s_gray,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [RGB_W-1:0]  m_rgb,
  output logic              m_sof,
  output logic              m_eol,
  output logic              len_err,
  output logic [15:0]       frame_cnt
);

  localparam logic [COL_W-1:0] COL_MAX  = {COL_W{1'b1}};
  localparam logic [COL_W:0]   LINE_LEN = (COL_W + 1)'(LINE_W);

  logic              v1_q, v1_d, sof1_q, sof1_d, eol1_q, eol1_d;
  logic [GRAY_W-1:0] gray1_q, gray1_d;
  logic              v2_q, v2_d, sof2_q, sof2_d, eol2_q, eol2_d;
  rgb_t              rgb2_q, rgb2_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              len_err_q, len_err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              adv1, adv2, accept;
  logic [COL_W-1:0]  eff_col;
  logic [COL_W:0]    eff_len;
  rgb_t              map_rgb;

  gray_colormap u_colormap (
    .gray_i (gray1_q),
    .rgb_o  (map_rgb)
  );

  assign adv2    = !v2_q || m_ready;
  assign adv1    = !v1_q || adv2;
  assign accept  = s_valid && adv1;
  // Flops are held in reset anyway; rst only masks the port so upstream sees no accept
  assign s_ready = adv1 && !rst;

  assign eff_col = s_sof ? '0 : col_q;
  assign eff_len = {1'b0, eff_col} + 1'b1;

  always_comb begin
    v1_d        = v1_q;
    gray1_d     = gray1_q;
    sof1_d      = sof1_q;
    eol1_d      = eol1_q;
    v2_d        = v2_q;
    rgb2_d      = rgb2_q;
    sof2_d      = sof2_q;
    eol2_d      = eol2_q;
    col_d       = col_q;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        gray1_d = s_gray;
        sof1_d  = s_sof;
        eol1_d  = s_eol;
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        rgb2_d = map_rgb;
        sof2_d = sof1_q;
        eol2_d = eol1_q;
      end
    end

    if (accept) begin
      if (s_eol) begin
        len_err_d = (eff_len != LINE_LEN);
        col_d     = '0;
      end else if (eff_col == COL_MAX) begin
        col_d = COL_MAX;
      end else begin
        col_d = eff_len[COL_W-1:0];
      end
      if (s_sof) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      gray1_q     <= '0;
      sof1_q      <= 1'b0;
      eol1_q      <= 1'b0;
      v2_q        <= 1'b0;
      rgb2_q      <= '0;
      sof2_q      <= 1'b0;
      eol2_q      <= 1'b0;
      col_q       <= '0;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      v1_q        <= v1_d;
      gray1_q     <= gray1_d;
      sof1_q      <= sof1_d;
      eol1_q      <= eol1_d;
      v2_q        <= v2_d;
      rgb2_q      <= rgb2_d;
      sof2_q      <= sof2_d;
      eol2_q      <= eol2_d;
      col_q       <= col_d;
      len_err_q   <= len_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_valid   = v2_q;
  assign m_rgb     = rgb2_q;
  assign m_sof     = sof2_q;
  assign m_eol     = eol2_q;
  assign len_err   = len_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
